clk_div_bank: RTL

Parametrised clock-enable and blink generator for the video/display path. Derives one pixel-rate strobe/square wave and NCH independently programmable low-rate square waves (cursor/alarm blink) from CLK_NX. All outputs are registered, single clock domain, and intended as clock enables for downstream logic, not as clocks.

---
 rtl/clk_div_bank.sv | 131 +++++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// Pixel-rate strobe/square-wave generator plus NCH programmable blink channels, all on CLK_NX.
// Optional macro DIVBANK_PIXSYNC_EN: channel counters advance only on pixel-tick edges.
module clk_div_bank #(
    parameter int PIX_DIV      = 4,
    parameter int NCH          = 2,
    parameter int CW           = 24,
    parameter int DEFAULT_HALF = 12500000
) (
    input  logic              CLK_NX,
    input  logic              reset,
    output logic              pix_tick,
    output logic              pix_level,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    ch_load,
    input  logic [NCH*CW-1:0] ch_half,
    output logic [NCH-1:0]    ch_level,
    output logic [NCH-1:0]    ch_tick,
    output logic [NCH-1:0]    ch_err
);

    localparam int              PCW     = $clog2(PIX_DIV);
    localparam logic [PCW-1:0]  PC_LAST = PCW'(PIX_DIV - 1);
    localparam logic [PCW-1:0]  PC_MID  = PCW'(PIX_DIV / 2 - 1);
    localparam logic [PCW-1:0]  PC_ONE  = PCW'(1);
    localparam logic [CW-1:0]   H_RESET = CW'(DEFAULT_HALF);
    localparam logic [CW-1:0]   CW_ZERO = CW'(0);
    localparam logic [CW-1:0]   CW_ONE  = CW'(1);

    logic [PCW-1:0] pc_r;
    logic           pix_tick_r;
    logic           pix_level_r;
    logic           pc_wrap_s;
    logic           adv_s;

    logic [CW-1:0]  half_s [NCH];
    logic [CW-1:0]  h_r    [NCH];
    logic [CW-1:0]  h_s    [NCH];
    logic [CW-1:0]  c_r    [NCH];
    logic [CW-1:0]  c_s    [NCH];
    logic [NCH-1:0] lvl_r, lvl_s;
    logic [NCH-1:0] tick_r, tick_s;
    logic [NCH-1:0] err_r, err_s;

    assign pc_wrap_s = (pc_r == PC_LAST);

`ifdef DIVBANK_PIXSYNC_EN
    assign adv_s = pc_wrap_s;
`else
    assign adv_s = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slice
            assign half_s[gi] = ch_half[gi*CW +: CW];
        end
    endgenerate

    // Free-running pixel counter with its tick and 50 % level.
    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            pc_r        <= '0;
            pix_tick_r  <= 1'b0;
            pix_level_r <= 1'b0;
        end else begin
            pc_r        <= pc_wrap_s ? '0 : pc_r + PC_ONE;
            pix_tick_r  <= pc_wrap_s;
            pix_level_r <= (pc_wrap_s || (pc_r == PC_MID)) ? ~pix_level_r : pix_level_r;
        end
    end

    // Per-channel next state: load beats disable, disable beats counting.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            h_s[i]    = h_r[i];
            c_s[i]    = c_r[i];
            lvl_s[i]  = lvl_r[i];
            tick_s[i] = 1'b0;
            err_s[i]  = err_r[i];
            if (ch_load[i]) begin
                c_s[i] = CW_ZERO;
                if (half_s[i] != CW_ZERO) begin
                    h_s[i] = half_s[i];
                end else begin
                    err_s[i] = 1'b1;
                end
            end else if (!ch_en[i]) begin
                c_s[i]   = CW_ZERO;
                lvl_s[i] = 1'b0;
            end else if (adv_s) begin
                if (c_r[i] == h_r[i] - CW_ONE) begin
                    c_s[i]    = CW_ZERO;
                    lvl_s[i]  = ~lvl_r[i];
                    tick_s[i] = 1'b1;
                end else begin
                    c_s[i] = c_r[i] + CW_ONE;
                end
            end else begin
                c_s[i] = c_r[i];
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                h_r[i] <= H_RESET;
                c_r[i] <= CW_ZERO;
            end
            lvl_r  <= '0;
            tick_r <= '0;
            err_r  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                h_r[i] <= h_s[i];
                c_r[i] <= c_s[i];
            end
            lvl_r  <= lvl_s;
            tick_r <= tick_s;
            err_r  <= err_s;
        end
    end

    assign pix_tick  = pix_tick_r;
    assign pix_level = pix_level_r;
    assign ch_level  = lvl_r;
    assign ch_tick   = tick_r;
    assign ch_err    = err_r;

endmodule
